// File: rtl/rename_controller.sv
// Rename controller: circular ROB tag queue with RAT request/remove sequencing and a flush walk.
// Ready and RAT port outputs are combinational; a flush walks every arch id before dispatch resumes.
module rename_controller #(
   parameter int ARCH_ENTRY      = 32,
   parameter int ROB_ENTRY       = 4,
   parameter int ARCH_ENTRY_LOG2 = $clog2(ARCH_ENTRY),
   parameter int ROB_ENTRY_LOG2  = $clog2(ROB_ENTRY)
) (
   input  logic                       CLK,
   input  logic                       RSTN,
   input  logic                       disp_valid,
   input  logic                       disp_rd_we,
   input  logic [ARCH_ENTRY_LOG2-1:0] disp_rd_id,
   output logic                       disp_ready,
   output logic [ROB_ENTRY_LOG2-1:0]  disp_rob_tag,
   input  logic                       cmt_valid,
   output logic                       cmt_ready,
   output logic [ROB_ENTRY_LOG2-1:0]  cmt_tag,
   input  logic                       flush,
   output logic                       flush_busy,
   output logic                       rat_register_request,
   output logic                       rat_register_remove,
   output logic [ARCH_ENTRY_LOG2-1:0] rat_register_arch_id,
   output logic [ROB_ENTRY_LOG2-1:0]  rat_register_alias,
   output logic [ARCH_ENTRY_LOG2-1:0] rat_chk_arch_id,
   input  logic                       rat_chk_busy,
   input  logic [ROB_ENTRY_LOG2-1:0]  rat_chk_alias
);

   typedef enum logic {ST_RUN, ST_FLUSH} state_t;

   localparam logic [ROB_ENTRY_LOG2:0]    FULL_CNT  = (ROB_ENTRY_LOG2+1)'(ROB_ENTRY);
   localparam logic [ARCH_ENTRY_LOG2-1:0] WALK_LAST = ARCH_ENTRY_LOG2'(ARCH_ENTRY-1);

   state_t                       state_q, state_d;
   logic [ROB_ENTRY_LOG2-1:0]    head_q, head_d;
   logic [ROB_ENTRY_LOG2-1:0]    tail_q, tail_d;
   logic [ROB_ENTRY_LOG2:0]      count_q, count_d;
   logic [ARCH_ENTRY_LOG2-1:0]   walk_q, walk_d;
   logic [ARCH_ENTRY_LOG2-1:0]   rd_id_q [ROB_ENTRY];
   logic                         rd_we_q [ROB_ENTRY];

   logic [ARCH_ENTRY_LOG2-1:0]   head_rd_id;
   logic                         head_rd_we;
   logic                         running;
   logic                         not_empty;
   logic                         need_rm;
   logic                         need_reg;
   logic                         disp_fire;
   logic                         cmt_fire;

   assign head_rd_id = rd_id_q[head_q];
   assign head_rd_we = rd_we_q[head_q];
   assign running    = (state_q == ST_RUN);
   assign not_empty  = (count_q != '0);

   // A remove is only legal while the RAT still maps the head's rd to the head tag.
   assign need_rm  = not_empty && head_rd_we && (head_rd_id != '0) &&
                     rat_chk_busy && (rat_chk_alias == head_q);
   assign need_reg = disp_valid && disp_rd_we && (disp_rd_id != '0);

   assign cmt_ready  = running && !flush && not_empty;
   // The RAT has one write port: a remove and a request for different arch ids cannot share a cycle.
   assign disp_ready = running && !flush && (count_q < FULL_CNT) &&
                       !(cmt_valid && need_rm && need_reg && (disp_rd_id != head_rd_id));

   assign disp_fire = disp_valid && disp_ready;
   assign cmt_fire  = cmt_valid && cmt_ready;

   assign disp_rob_tag    = tail_q;
   assign cmt_tag         = head_q;
   assign rat_chk_arch_id = head_rd_id;
   assign flush_busy      = (state_q == ST_FLUSH);

   always_comb begin
      rat_register_request = 1'b0;
      rat_register_remove  = 1'b0;
      rat_register_arch_id = '0;
      rat_register_alias   = '0;
      if (!running) begin
         rat_register_remove  = 1'b1;
         rat_register_arch_id = walk_q;
      end else if (disp_fire && need_reg) begin
         rat_register_request = 1'b1;
         rat_register_arch_id = disp_rd_id;
         rat_register_alias   = tail_q;
      end else if (cmt_fire && need_rm) begin
         rat_register_remove  = 1'b1;
         rat_register_arch_id = head_rd_id;
         rat_register_alias   = head_q;
      end
   end

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      walk_d  = walk_q;
      case (state_q)
         ST_RUN: begin
            if (flush) begin
               head_d  = '0;
               tail_d  = '0;
               count_d = '0;
               walk_d  = '0;
               state_d = ST_FLUSH;
            end else begin
               if (disp_fire) tail_d = tail_q + 1'b1;
               if (cmt_fire)  head_d = head_q + 1'b1;
               if (disp_fire && !cmt_fire)      count_d = count_q + 1'b1;
               else if (!disp_fire && cmt_fire) count_d = count_q - 1'b1;
            end
         end
         ST_FLUSH: begin
            walk_d = walk_q + 1'b1;
            if (walk_q == WALK_LAST) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q <= ST_RUN;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         walk_q  <= '0;
         for (int i = 0; i < ROB_ENTRY; i++) begin
            rd_id_q[i] <= '0;
            rd_we_q[i] <= 1'b0;
         end
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         walk_q  <= walk_d;
         if (disp_fire) begin
            rd_id_q[tail_q] <= disp_rd_id;
            rd_we_q[tail_q] <= disp_rd_we;
         end
      end
   end

endmodule
